dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single data RAM (ram: clk, ena, wena, 2-bit mode, 13-bit addr) between two masters:
//   M0 = CPU data port, M1 = loader/debug port. Round-robin arbitration with optional lock and
//   a bounded hold. Sits between the masters and ram inside the top-level dataflow wrapper.
//   One RAM access per cycle; read data is returned registered, one cycle after grant.
// PARAMETERS
//   MAX_HOLD  16  max consecutive locked grants to one master while the other requests (>=1)
//   AW        13  RAM address width (word/byte address bits passed to ram)
// PORTS
//   clk_in      in   1   system clock, all state on rising edge
//   reset       in   1   synchronous, active-low (reset==0 resets on the clk_in edge)
//   mX_req      in   1   X in {0,1}: access request; fields below held stable until mX_gnt
//   mX_lock     in   1   keep ownership after this grant (burst)
//   mX_we       in   1   1 = write, 0 = read
//   mX_mode     in   2   access size code, passed unchanged to ram_mode
//   mX_addr     in   32  byte address; only [AW-1:0] used, upper bits ignored
//   mX_wdata    in   32  write data
//   mX_gnt      out  1   combinational: access issued to RAM this cycle
//   mX_rvalid   out  1   registered: mX_rdata valid (one cycle after a read grant)
//   mX_rdata    out  32  registered read data
//   ram_ena     out  1   RAM enable, 1 only in a granted cycle
//   ram_wena    out  1   = granted master's we
//   ram_mode    out  2   = granted master's mode
//   ram_addr    out  AW  = granted master's addr[AW-1:0]
//   ram_wdata   out  32  = granted master's wdata
//   ram_rdata   in   32  RAM read data (combinational from ram_addr)
// BEHAVIOUR
//   Reset (reset==0 at edge): state=IDLE, last=1 (M0 wins first tie), hold_cnt=0,
//     m0/m1_rvalid=0, m0/m1_rdata=0. gnt/ram_* are combinational, 0 when no req.
//   Reset mid-burst or with a read outstanding: lock dropped, pending rvalid suppressed.
//   FSM states: IDLE, LOCK0, LOCK1. At most one gnt per cycle; gnt implies ram_ena=1.
//   IDLE: only one req -> grant it. Both -> grant the master != last. Winner w: last<=w;
//     if mw_lock -> LOCKw, hold_cnt<=1; else stay IDLE.
//   LOCKx, mx_req=0: lock released; arbitrate this cycle exactly as IDLE.
//   LOCKx, mx_req=1, (other req=0 or hold_cnt<MAX_HOLD): grant x; hold_cnt<=hold_cnt+1
//     (saturate at MAX_HOLD); if mx_lock=0 -> IDLE.
//   LOCKx, mx_req=1, other req=1, hold_cnt==MAX_HOLD: forced release: grant other (y),
//     last<=y; next LOCKy (hold_cnt<=1) if my_lock else IDLE; x then waits for round-robin.
//   Read response: on a granted read, next edge mX_rdata<=ram_rdata, mX_rvalid<=1 for one
//     cycle; otherwise mX_rvalid<=0 and mX_rdata holds. Writes: committed by ram at the
//     grant edge; no response. Back-to-back reads give rvalid on consecutive cycles.
//   Read-after-write same addr, consecutive grants: read returns new data (ram writes at edge).
//   hold_cnt width $clog2(MAX_HOLD+1); no wrap (saturates). last only changes on a grant.
// STRUCTURE
//   Shared package: state encodings (IDLE/LOCK0/LOCK1), master index constants, mode codes
//     shared with cpu/ram (word/half/byte).
//   One sub-module: dmem_rr_pick (2-way round-robin pick from req[1:0], last -> winner, valid).
//   Rest is flat: FSM + hold counter, output mux, response registers.
// TESTING
//   1. reset=0 2 cycles, then both idle -> all gnt/rvalid/ram_ena 0, rdata 0.
//   2. m0 write addr 0x10 data 0xDEADBEEF, next cycle m0 read 0x10 -> m0_rvalid=1, rdata=0xDEADBEEF.
//   3. m0,m1 req every cycle, no lock -> gnt alternates M0,M1,M0,... starting with M0.
//   4. m1 lock+req continuously, m0 req from cycle 3, MAX_HOLD=4 -> m1 gets 4 grants, then m0
//      granted exactly once, then m1 regains.
//   5. m0 read granted, reset=0 next edge -> m0_rvalid stays 0; state IDLE, last=1.
//   6. m0 lock burst, m0_req drops for one cycle while m1 req -> m1 granted that same cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// master index constants and the RAM access-size codes used by cpu/ram.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    // Locked state that belongs to a given master index.
    function automatic arb_state_t lock_state_of(input logic idx);
        return idx ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the master that did not win last time
// is chosen; a lone requester always wins.
module dmem_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner,
    output logic       o_valid
);

    // Pure combinational selection between the two requesters.
    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        if (i_req == 2'b11) begin
            o_winner = ~i_last;
        end else if (i_req[1]) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data RAM between the CPU data port (M0) and the
// loader/debug port (M1). Round-robin with optional burst lock; a locked
// owner is pre-empted after MAX_HOLD grants if the other master is waiting.
// Grants and RAM drive are combinational; read data comes back registered
// one cycle after the grant.
//
// Handshake: a master raises mX_req with its fields stable and keeps them
// stable until the cycle in which mX_gnt is high; that cycle is the RAM
// access. A read's data arrives with mX_rvalid exactly one cycle later.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int AW       = 13,
    localparam int HCW     = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_lock,
    input  logic            m0_we,
    input  logic [1:0]      m0_mode,
    input  logic [31:0]     m0_addr,
    input  logic [31:0]     m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [31:0]     m0_rdata,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic            m1_we,
    input  logic [1:0]      m1_mode,
    input  logic [31:0]     m1_addr,
    input  logic [31:0]     m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [31:0]     m1_rdata,
    output logic            ram_ena,
    output logic            ram_wena,
    output logic [1:0]      ram_mode,
    output logic [AW-1:0]   ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata,
    output arb_state_t      dbg_state,
    output logic            dbg_last,
    output logic [HCW-1:0]  dbg_hold_cnt
);

    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

    arb_state_t     r_state;
    logic           r_last;
    logic [HCW-1:0] r_hold_cnt;
    logic           r_m0_rvalid;
    logic           r_m1_rvalid;
    logic [31:0]    r_m0_rdata;
    logic [31:0]    r_m1_rdata;

    logic           w_pick_winner;
    logic           w_pick_valid;
    logic           w_own_idx;
    logic           w_own_req;
    logic           w_other_req;
    logic           w_forced;
    logic           w_grant;
    logic           w_win;
    logic           w_win_lock;
    logic           w_win_we;
    arb_state_t     w_next_state;
    logic [HCW-1:0] w_next_hold;
    logic [HCW-1:0] w_hold_inc;

    // Upper address bits are deliberately ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{m0_addr[31:AW], m1_addr[31:AW]};

    dmem_rr_pick u_pick (
        .i_req    ({m1_req, m0_req}),
        .i_last   (r_last),
        .o_winner (w_pick_winner),
        .o_valid  (w_pick_valid)
    );

    // Who currently owns a lock, whether it still wants the RAM, and whether
    // the hold budget is exhausted while the other master waits.
    always_comb begin
        w_own_idx   = (r_state == ST_LOCK1);
        w_own_req   = ((r_state == ST_LOCK0) && m0_req) ||
                      ((r_state == ST_LOCK1) && m1_req);
        w_other_req = w_own_idx ? m0_req : m1_req;
        w_forced    = w_own_req && w_other_req && (r_hold_cnt == HOLD_MAX);
        w_hold_inc  = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HOLD_ONE;
    end

    // Choose this cycle's winner: locked owner, forced hand-over, or round-robin.
    always_comb begin
        w_grant = 1'b0;
        w_win   = M0;
        if (w_own_req && !w_forced) begin
            w_grant = 1'b1;
            w_win   = w_own_idx;
        end else if (w_forced) begin
            w_grant = 1'b1;
            w_win   = ~w_own_idx;
        end else if (w_pick_valid) begin
            w_grant = 1'b1;
            w_win   = w_pick_winner;
        end
        w_win_lock = w_win ? m1_lock : m0_lock;
        w_win_we   = w_win ? m1_we   : m0_we;
    end

    // Next FSM state and hold count; a continuing owner keeps counting,
    // any fresh owner starts at one.
    always_comb begin
        w_next_state = ST_IDLE;
        w_next_hold  = '0;
        if (w_grant && w_win_lock) begin
            w_next_state = lock_state_of(w_win);
            w_next_hold  = (w_own_req && !w_forced) ? w_hold_inc : HOLD_ONE;
        end
    end

    // Drive the RAM from the granted master; everything idles at zero otherwise.
    always_comb begin
        m0_gnt    = w_grant && (w_win == M0);
        m1_gnt    = w_grant && (w_win == M1);
        ram_ena   = w_grant;
        ram_wena  = 1'b0;
        ram_mode  = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_grant) begin
            ram_wena  = w_win_we;
            ram_mode  = w_win ? m1_mode : m0_mode;
            ram_addr  = w_win ? m1_addr[AW-1:0] : m0_addr[AW-1:0];
            ram_wdata = w_win ? m1_wdata : m0_wdata;
        end
    end

    // Arbitration state and registered read responses.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last      <= M1;
            r_hold_cnt  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_next_hold;
            if (w_grant) begin
                r_last <= w_win;
            end
            r_m0_rvalid <= m0_gnt && !m0_we;
            r_m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                r_m0_rdata <= ram_rdata;
            end
            if (m1_gnt && !m1_we) begin
                r_m1_rdata <= ram_rdata;
            end
        end
    end

    assign m0_rvalid    = r_m0_rvalid;
    assign m1_rvalid    = r_m1_rvalid;
    assign m0_rdata     = r_m0_rdata;
    assign m1_rdata     = r_m1_rdata;
    assign dbg_state    = r_state;
    assign dbg_last     = r_last;
    assign dbg_hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with MAX_HOLD=4: a driver applies one
// vector per cycle and queues the expected bus activity and read data; a
// negedge monitor pops and compares. A behavioural RAM sits on the ram_* side.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int MAX_HOLD = 4;
    localparam int AW       = 13;
    localparam int HCW      = $clog2(MAX_HOLD + 1);
    localparam int EW       = 51;

    typedef struct {
        logic        req;
        logic        lock;
        logic        we;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    logic m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
    logic m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
    logic [1:0]  m0_mode = '0, m1_mode = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ena, ram_wena;
    logic [1:0]  ram_mode;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    arb_state_t  dbg_state;
    logic        dbg_last;
    logic [HCW-1:0] dbg_hold_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic mon_on = 1'b0;

    logic [EW-1:0] exp_q[$];
    logic [63:0]   rd0_q[$];
    logic [63:0]   rd1_q[$];

    logic [31:0] mem [0:(1<<AW)-1];

    dmem_arbiter #(.MAX_HOLD(MAX_HOLD), .AW(AW)) dut (
        .clk_in(clk_in), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_mode(m0_mode),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_mode(m1_mode),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_mode(ram_mode),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state), .dbg_last(dbg_last), .dbg_hold_cnt(dbg_hold_cnt)
    );

    // Clock and cycle counter
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Behavioural RAM: write at the edge, combinational read
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end
    always @(posedge clk_in) begin
        if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mreq_t mk(input logic req, input logic lock, input logic we,
                                 input logic [1:0] mode, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        mreq_t m;
        m.req = req; m.lock = lock; m.we = we; m.mode = mode; m.addr = addr; m.wdata = wdata;
        return m;
    endfunction

    function automatic mreq_t none();
        return mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endfunction

    // Driver: apply one cycle of requests and queue the expected outcome.
    // eg is the hand-computed grant vector {m1,m0}; erd the expected read data.
    task automatic drive(input mreq_t a, input mreq_t b, input logic [1:0] eg,
                         input logic [31:0] erd, input logic exp_rv);
        mreq_t sel;
        logic [EW-1:0] e;
        @(posedge clk_in);
        #1;
        m0_req = a.req; m0_lock = a.lock; m0_we = a.we; m0_mode = a.mode;
        m0_addr = a.addr; m0_wdata = a.wdata;
        m1_req = b.req; m1_lock = b.lock; m1_we = b.we; m1_mode = b.mode;
        m1_addr = b.addr; m1_wdata = b.wdata;
        sel = (eg == 2'b10) ? b : a;
        if (eg == 2'b00) e = '0;
        else e = {eg, 1'b1, sel.we, sel.mode, sel.addr[AW-1:0], sel.wdata};
        exp_q.push_back(e);
        if (exp_rv && eg != 2'b00 && !sel.we) begin
            if (eg == 2'b01) rd0_q.push_back({32'(cyc + 1), erd});
            else             rd1_q.push_back({32'(cyc + 1), erd});
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        repeat (n) @(posedge clk_in);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: bus activity every scheduled cycle, read responses every cycle
    logic [EW-1:0] mon_e;
    logic [63:0]   mon_r;
    always @(negedge clk_in) begin
        if (mon_on) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("bus", 64'({m1_gnt, m0_gnt, ram_ena, ram_wena, ram_mode, ram_addr, ram_wdata}),
                    64'(mon_e));
            end
            if (rd0_q.size() > 0 && rd0_q[0][63:32] == 32'(cyc)) begin
                mon_r = rd0_q.pop_front();
                chk("m0_rvalid", 64'(m0_rvalid), 64'(1));
                chk("m0_rdata", 64'(m0_rdata), 64'(mon_r[31:0]));
            end else begin
                chk("m0_rvalid_idle", 64'(m0_rvalid), 64'(0));
            end
            if (rd1_q.size() > 0 && rd1_q[0][63:32] == 32'(cyc)) begin
                mon_r = rd1_q.pop_front();
                chk("m1_rvalid", 64'(m1_rvalid), 64'(1));
                chk("m1_rdata", 64'(m1_rdata), 64'(mon_r[31:0]));
            end else begin
                chk("m1_rvalid_idle", 64'(m1_rvalid), 64'(0));
            end
        end
    end

    initial begin
        // 1: reset held two cycles, both masters idle
        do_reset(2);
        mon_on = 1'b1;
        @(negedge clk_in);
        chk("rst_gnt", 64'({m1_gnt, m0_gnt, ram_ena}), 64'(0));
        chk("rst_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'(0));
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_last", 64'(dbg_last), 64'(1));

        // 3: both request every cycle without lock -> M0, M1, M0, M1
        drive(mk(1,0,1,MODE_WORD,32'h20,32'h1111_1111), mk(1,0,0,MODE_HALF,32'h20,0), 2'b01, 0, 0);
        drive(mk(1,0,1,MODE_WORD,32'h24,32'h2222_2222), mk(1,0,0,MODE_HALF,32'h20,0), 2'b10, 32'h1111_1111, 1);
        drive(mk(1,0,1,MODE_WORD,32'h24,32'h2222_2222), mk(1,0,0,MODE_HALF,32'h24,0), 2'b01, 0, 0);
        drive(mk(1,0,0,MODE_WORD,32'h20,0),             mk(1,0,0,MODE_HALF,32'h24,0), 2'b10, 32'h2222_2222, 1);
        drive(mk(1,0,0,MODE_BYTE,32'h20,0),             none(),                       2'b01, 32'h1111_1111, 1);

        // 2: write then read, upper address bits ignored, back-to-back reads
        drive(mk(1,0,1,MODE_WORD,32'h10,32'hDEAD_BEEF), none(), 2'b01, 0, 0);
        drive(mk(1,0,0,MODE_WORD,32'hFFFF_0010,0),      none(), 2'b01, 32'hDEAD_BEEF, 1);
        drive(mk(1,0,0,MODE_WORD,32'h24,0),             none(), 2'b01, 32'h2222_2222, 1);

        // 4: M1 locked burst, M0 joins at cycle 3 -> 4 M1 grants, one forced M0, M1 again
        drive(none(),                                   mk(1,1,0,MODE_HALF,32'h10,0), 2'b10, 32'hDEAD_BEEF, 1);
        drive(none(),                                   mk(1,1,0,MODE_HALF,32'h10,0), 2'b10, 32'hDEAD_BEEF, 1);
        drive(none(),                                   mk(1,1,0,MODE_HALF,32'h10,0), 2'b10, 32'hDEAD_BEEF, 1);
        drive(mk(1,0,1,MODE_WORD,32'h30,32'h3333_3333), mk(1,1,0,MODE_HALF,32'h10,0), 2'b10, 32'hDEAD_BEEF, 1);
        drive(mk(1,0,1,MODE_WORD,32'h30,32'h3333_3333), mk(1,1,0,MODE_HALF,32'h10,0), 2'b01, 0, 0);
        drive(mk(1,0,1,MODE_WORD,32'h34,32'h4444_4444), mk(1,1,0,MODE_HALF,32'h10,0), 2'b10, 32'hDEAD_BEEF, 1);
        drive(mk(1,0,1,MODE_WORD,32'h34,32'h4444_4444), mk(1,0,0,MODE_HALF,32'h10,0), 2'b10, 32'hDEAD_BEEF, 1);
        drive(mk(1,0,1,MODE_WORD,32'h34,32'h4444_4444), none(),                       2'b01, 0, 0);
        drive(none(),                                   mk(1,0,0,MODE_BYTE,32'h30,0), 2'b10, 32'h3333_3333, 1);

        // 6: M0 locked burst, M0 drops req for a cycle while M1 waits
        drive(mk(1,1,1,MODE_WORD,32'h40,32'h5555_5555), none(),                       2'b01, 0, 0);
        drive(mk(1,1,0,MODE_WORD,32'h40,0),             none(),                       2'b01, 32'h5555_5555, 1);
        drive(none(),                                   mk(1,0,0,MODE_HALF,32'h34,0), 2'b10, 32'h4444_4444, 1);
        drive(mk(1,1,0,MODE_WORD,32'h40,0),             none(),                       2'b01, 32'h5555_5555, 1);

        // 5: locked read granted, reset at the next edge -> no rvalid, IDLE, last=1
        drive(mk(1,1,0,MODE_WORD,32'h24,0),             none(),                       2'b01, 0, 0);
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        @(negedge clk_in);
        chk("rst_mid_rvalid", 64'(m0_rvalid), 64'(0));
        chk("rst_mid_rdata", 64'(m0_rdata), 64'(0));
        chk("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_mid_last", 64'(dbg_last), 64'(1));
        chk("rst_mid_hold", 64'(dbg_hold_cnt), 64'(0));

        // Drain and confirm every expectation was consumed
        drive(none(), none(), 2'b00, 0, 0);
        drive(none(), none(), 2'b00, 0, 0);
        @(posedge clk_in);
        #1;
        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
        chk("rd0_q_empty", 64'(rd0_q.size()), 64'(0));
        chk("rd1_q_empty", 64'(rd1_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
